// File: rtl/fa_response_checker.sv
// Purpose : full-adder response checker; samples y0/y1 once per settled {a,b,c} vector against a^b^c / majority.
// Latency : a vector latched at edge T0 and held stable is checked at edge T0+SETTLE; chk_valid is high the following cycle.
// Backpr. : none; observe-only monitor, an input change before the settle window ends discards that vector.
// Ports   : clk/rst (async active-high), en, clear (sync), monitored a/b/c/y0/y1,
//           chk_valid/chk_pass pulse, saturating check_count/error_count, first-error capture,
//           vec_cov (per vector), trans_cov (per ordered vector pair), all_covered.
module fa_response_checker #(
    parameter int SETTLE = 4,
    parameter int CW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clear,
    input  logic          a,
    input  logic          b,
    input  logic          c,
    input  logic          y0,
    input  logic          y1,
    output logic          chk_valid,
    output logic          chk_pass,
    output logic [CW-1:0] check_count,
    output logic [CW-1:0] error_count,
    output logic          first_err_valid,
    output logic [2:0]    first_err_vec,
    output logic [1:0]    first_err_got,
    output logic [7:0]    vec_cov,
    output logic [63:0]   trans_cov,
    output logic          all_covered
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_WAIT} state_t;

    // cnt counts stable cycles since the latch edge; CHECK is entered once it reaches SETTLE-1
    localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);
    // With SETTLE==1 the latch edge already satisfies the window, so go straight to CHECK
    localparam state_t LATCH_NXT = (SETTLE == 1) ? S_CHECK : S_SETTLE;
    // Diagonal {v,v} transitions can never occur; mask them out of the coverage test
    localparam logic [63:0] DIAG = 64'h8040_2010_0804_0201;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_t      state;
    logic [7:0]  cnt;
    logic [2:0]  vec;
    logic [2:0]  last_checked;
    logic        have_prev;

    logic [2:0]  cur;
    logic        exp_y0;
    logic        exp_y1;
    logic        pass;

    assign cur    = {a, b, c};
    assign exp_y0 = vec[2] ^ vec[1] ^ vec[0];
    assign exp_y1 = (vec[2] & vec[1]) | (vec[1] & vec[0]) | (vec[2] & vec[0]);
    assign pass   = ({y1, y0} == {exp_y1, exp_y0});

    assign all_covered = (&vec_cov) && (&(trans_cov | DIAG));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            cnt             <= '0;
            vec             <= '0;
            last_checked    <= '0;
            have_prev       <= 1'b0;
            chk_valid       <= 1'b0;
            chk_pass        <= 1'b0;
            check_count     <= '0;
            error_count     <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
            first_err_got   <= '0;
            vec_cov         <= '0;
            trans_cov       <= '0;
        end else begin
            chk_valid <= 1'b0;
            if (clear) begin
                // Wins over a coincident check: that sample is dropped
                state           <= S_IDLE;
                cnt             <= '0;
                vec             <= '0;
                last_checked    <= '0;
                have_prev       <= 1'b0;
                chk_pass        <= 1'b0;
                check_count     <= '0;
                error_count     <= '0;
                first_err_valid <= 1'b0;
                first_err_vec   <= '0;
                first_err_got   <= '0;
                vec_cov         <= '0;
                trans_cov       <= '0;
            end else if (!en) begin
                // Pending settle/check is abandoned; results hold
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        vec   <= cur;
                        cnt   <= '0;
                        state <= LATCH_NXT;
                    end
                    S_SETTLE: begin
                        if (cur != vec) begin
                            vec   <= cur;
                            cnt   <= '0;
                            state <= LATCH_NXT;
                        end else begin
                            cnt <= cnt + 8'd1;
                            if (cnt + 8'd1 == CNT_LAST) begin
                                state <= S_CHECK;
                            end
                        end
                    end
                    S_CHECK: begin
                        chk_valid <= 1'b1;
                        chk_pass  <= pass;
                        if (check_count != CNT_MAX) begin
                            check_count <= check_count + CW'(1);
                        end
                        if (!pass) begin
                            if (error_count != CNT_MAX) begin
                                error_count <= error_count + CW'(1);
                            end
                            if (!first_err_valid) begin
                                first_err_valid <= 1'b1;
                                first_err_vec   <= vec;
                                first_err_got   <= {y1, y0};
                            end
                        end
                        vec_cov[vec] <= 1'b1;
                        if (have_prev && (last_checked != vec)) begin
                            trans_cov[{last_checked, vec}] <= 1'b1;
                        end
                        last_checked <= vec;
                        have_prev    <= 1'b1;
                        state        <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (cur != vec) begin
                            vec   <= cur;
                            cnt   <= '0;
                            state <= LATCH_NXT;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fa_response_checker.sv
// Purpose : self-checking bench for fa_response_checker against a segment-level scoreboard model.
// Latency : expects each settled vector's check at edge (latch edge + SETTLE).
// Backpr. : n/a; stimulus is a list of (vector, hold-cycles) segments.
module tb_fa_response_checker;

    localparam int SETTLE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic clear = 1'b0;
    logic a = 1'b0, b = 1'b0, c = 1'b0;
    logic y0, y1;
    bit   stuck = 1'b0;

    logic        chk_valid, chk_pass, first_err_valid, all_covered;
    logic [15:0] check_count, error_count;
    logic [2:0]  first_err_vec;
    logic [1:0]  first_err_got;
    logic [7:0]  vec_cov;
    logic [63:0] trans_cov;

    logic        s_chk_valid, s_chk_pass, s_first_err_valid, s_all_covered;
    logic [2:0]  s_check_count, s_error_count;
    logic [2:0]  s_first_err_vec;
    logic [1:0]  s_first_err_got;
    logic [7:0]  s_vec_cov;
    logic [63:0] s_trans_cov;

    // DUT being checked: a full adder, optionally with carry stuck at 0
    assign y0 = a ^ b ^ c;
    assign y1 = stuck ? 1'b0 : ((a & b) | (b & c) | (a & c));

    fa_response_checker #(.SETTLE(SETTLE), .CW(16)) dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .a(a), .b(b), .c(c), .y0(y0), .y1(y1),
        .chk_valid(chk_valid), .chk_pass(chk_pass), .check_count(check_count),
        .error_count(error_count), .first_err_valid(first_err_valid),
        .first_err_vec(first_err_vec), .first_err_got(first_err_got),
        .vec_cov(vec_cov), .trans_cov(trans_cov), .all_covered(all_covered)
    );

    fa_response_checker #(.SETTLE(SETTLE), .CW(3)) dut_s (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .a(a), .b(b), .c(c), .y0(y0), .y1(y1),
        .chk_valid(s_chk_valid), .chk_pass(s_chk_pass), .check_count(s_check_count),
        .error_count(s_error_count), .first_err_valid(s_first_err_valid),
        .first_err_vec(s_first_err_vec), .first_err_got(s_first_err_got),
        .vec_cov(s_vec_cov), .trans_cov(s_trans_cov), .all_covered(s_all_covered)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Observed check pulses (cycle stamp, pass) sampled on the falling edge
    int obs_t[$];
    bit obs_p[$];
    always @(negedge clk) begin
        if (chk_valid === 1'b1) begin
            obs_t.push_back(cyc);
            obs_p.push_back(chk_pass);
        end
    end

    // Reference model state
    int       exp_t[$];
    bit       exp_p[$];
    int       m_checks, m_errs;
    bit       m_vseen[8];
    bit       m_tseen[8][8];
    bit       m_have_prev;
    int       m_last;
    bit       m_ferr;
    bit [2:0] m_fvec;
    bit [1:0] m_fgot;

    int seg_v[$];
    int seg_h[$];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_clear();
        m_checks = 0; m_errs = 0; m_have_prev = 0; m_last = 0;
        m_ferr = 0; m_fvec = '0; m_fgot = '0;
        for (int i = 0; i < 8; i++) begin
            m_vseen[i] = 0;
            for (int j = 0; j < 8; j++) m_tseen[i][j] = 0;
        end
    endtask

    // One settled vector is checked: golden sum = parity, carry = at least two ones
    task automatic model_check(input int v, output bit pass);
        int ones;
        bit [1:0] want, got;
        ones = $countones(v[2:0]);
        want = {ones >= 2, (ones % 2) == 1};
        got  = {stuck ? 1'b0 : (ones >= 2), (ones % 2) == 1};
        pass = (got == want);
        m_checks++;
        if (!pass) begin
            m_errs++;
            if (!m_ferr) begin
                m_ferr = 1; m_fvec = v[2:0]; m_fgot = got;
            end
        end
        m_vseen[v] = 1;
        if (m_have_prev && m_last != v) m_tseen[m_last][v] = 1;
        m_last = v;
        m_have_prev = 1;
    endtask

    function automatic void add_seg(input int v, input int h);
        if (seg_v.size() > 0 && seg_v[$] == v) seg_h[$] = seg_h[$] + h;
        else begin
            seg_v.push_back(v);
            seg_h.push_back(h);
        end
    endfunction

    task automatic build_random(input int n);
        int last, v, h;
        seg_v.delete(); seg_h.delete();
        last = -1;
        for (int i = 0; i < n; i++) begin
            do v = $urandom_range(0, 7); while (v == last);
            h = $urandom_range(1, 8);
            if (h == SETTLE) h = SETTLE + 1;
            if (i == n - 1) h = 7;
            add_seg(v, h);
            last = v;
        end
    endtask

    task automatic do_clear();
        en = 0; clear = 1;
        tick(1);
        clear = 0;
        model_clear();
    endtask

    // Plays the segment list from IDLE, scoreboards every check pulse, then compares final state
    task automatic run_segments(input string tag);
        int t, n;
        bit p, allc;
        bit [7:0]  ev;
        bit [63:0] et;
        obs_t.delete(); obs_p.delete(); exp_t.delete(); exp_p.delete();
        for (int i = 0; i < seg_v.size(); i++) begin
            {a, b, c} = 3'(seg_v[i]);
            en = 1;
            t = cyc;
            if (seg_h[i] > SETTLE) begin
                model_check(seg_v[i], p);
                exp_t.push_back(t + 1 + SETTLE);
                exp_p.push_back(p);
            end
            tick(seg_h[i]);
        end
        tick(1);
        en = 0;
        tick(1);
        checks++;
        if (obs_t.size() !== exp_t.size()) begin
            failures++;
            $display("FAIL %s pulse_count got=%0d want=%0d", tag, obs_t.size(), exp_t.size());
        end
        n = (obs_t.size() < exp_t.size()) ? obs_t.size() : exp_t.size();
        for (int k = 0; k < n; k++) begin
            checks++;
            if (obs_t[k] !== exp_t[k] || obs_p[k] !== exp_p[k]) begin
                failures++;
                $display("FAIL %s pulse%0d got cyc=%0d pass=%0d want cyc=%0d pass=%0d",
                         tag, k, obs_t[k], obs_p[k], exp_t[k], exp_p[k]);
            end
        end
        allc = 1;
        for (int i = 0; i < 8; i++) begin
            ev[i] = m_vseen[i];
            if (!m_vseen[i]) allc = 0;
            for (int j = 0; j < 8; j++) begin
                et[i*8+j] = m_tseen[i][j];
                if (i != j && !m_tseen[i][j]) allc = 0;
            end
        end
        checks++;
        if (check_count !== 16'(m_checks)) begin
            failures++;
            $display("FAIL %s check_count got=%0d want=%0d", tag, check_count, m_checks);
        end
        checks++;
        if (error_count !== 16'(m_errs)) begin
            failures++;
            $display("FAIL %s error_count got=%0d want=%0d", tag, error_count, m_errs);
        end
        checks++;
        if (vec_cov !== ev) begin
            failures++;
            $display("FAIL %s vec_cov got=%h want=%h", tag, vec_cov, ev);
        end
        checks++;
        if (trans_cov !== et) begin
            failures++;
            $display("FAIL %s trans_cov got=%h want=%h", tag, trans_cov, et);
        end
        checks++;
        if (all_covered !== allc) begin
            failures++;
            $display("FAIL %s all_covered got=%0d want=%0d", tag, all_covered, allc);
        end
        checks++;
        if (first_err_valid !== m_ferr ||
            (m_ferr && (first_err_vec !== m_fvec || first_err_got !== m_fgot))) begin
            failures++;
            $display("FAIL %s first_err got=%0d/%b/%b want=%0d/%b/%b", tag, first_err_valid,
                     first_err_vec, first_err_got, m_ferr, m_fvec, m_fgot);
        end
    endtask

    task automatic build_sweep();
        seg_v.delete(); seg_h.delete();
        for (int v = 0; v < 8; v++) add_seg(v, 10);
    endtask

    task automatic test_reset();
        rst = 1; en = 0; clear = 0; {a, b, c} = 3'b000;
        model_clear();
        tick(2);
        checks++;
        if (chk_valid !== 1'b0 || chk_pass !== 1'b0) begin
            failures++;
            $display("FAIL reset_pulse got=%b%b want=00", chk_valid, chk_pass);
        end
        checks++;
        if (check_count !== 16'd0 || error_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_counts got=%0d/%0d want=0/0", check_count, error_count);
        end
        checks++;
        if (vec_cov !== 8'd0 || trans_cov !== 64'd0 || all_covered !== 1'b0) begin
            failures++;
            $display("FAIL reset_cov got=%h/%h/%b want=0", vec_cov, trans_cov, all_covered);
        end
        checks++;
        if (first_err_valid !== 1'b0 || first_err_vec !== 3'd0 || first_err_got !== 2'd0) begin
            failures++;
            $display("FAIL reset_first_err got=%b/%b/%b want=0", first_err_valid, first_err_vec, first_err_got);
        end
        rst = 0;
        tick(1);
    endtask

    task automatic test_sweep();
        bit [63:0] tv;
        tv = '0;
        for (int i = 0; i < 7; i++) tv[9*i+1] = 1'b1;
        build_sweep();
        run_segments("sweep");
        checks++;
        if (check_count !== 16'd8 || error_count !== 16'd0) begin
            failures++;
            $display("FAIL sweep_counts got=%0d/%0d want=8/0", check_count, error_count);
        end
        checks++;
        if (vec_cov !== 8'hFF || trans_cov !== tv || all_covered !== 1'b0) begin
            failures++;
            $display("FAIL sweep_cov got=%h/%h/%b want=ff/%h/0", vec_cov, trans_cov, all_covered, tv);
        end
    endtask

    task automatic test_stuck();
        do_clear();
        stuck = 1;
        build_sweep();
        run_segments("stuck");
        stuck = 0;
        checks++;
        if (error_count !== 16'd4 || first_err_valid !== 1'b1 ||
            first_err_vec !== 3'b011 || first_err_got !== 2'b00) begin
            failures++;
            $display("FAIL stuck_summary got=%0d/%b/%b/%b want=4/1/011/00",
                     error_count, first_err_valid, first_err_vec, first_err_got);
        end
    endtask

    task automatic test_all_trans();
        bit [63:0] diag;
        diag = '0;
        for (int i = 0; i < 8; i++) diag[9*i] = 1'b1;
        do_clear();
        seg_v.delete(); seg_h.delete();
        for (int f = 0; f < 8; f++)
            for (int t = 0; t < 8; t++)
                if (f != t) begin
                    add_seg(f, 6);
                    add_seg(t, 6);
                end
        run_segments("all_trans");
        checks++;
        if (all_covered !== 1'b1 || (trans_cov & diag) !== 64'd0 || error_count !== 16'd0) begin
            failures++;
            $display("FAIL all_trans got=%b/%h/%0d want=1/0/0", all_covered, trans_cov & diag, error_count);
        end
    endtask

    task automatic test_glitch();
        do_clear();
        seg_v.delete(); seg_h.delete();
        add_seg(1, 2);
        add_seg(2, 10);
        run_segments("glitch");
        checks++;
        if (vec_cov !== 8'b0000_0100 || check_count !== 16'd1) begin
            failures++;
            $display("FAIL glitch got=%b/%0d want=00000100/1", vec_cov, check_count);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            stuck = 1'($urandom_range(0, 1));
            build_random(40);
            run_segments("random");
        end
        stuck = 0;
    endtask

    task automatic test_rst_abort();
        obs_t.delete(); obs_p.delete();
        en = 1; {a, b, c} = 3'b101;
        tick(2);
        #2 rst = 1;
        #1;
        checks++;
        if (check_count !== 16'd0 || error_count !== 16'd0 || vec_cov !== 8'd0 ||
            trans_cov !== 64'd0 || chk_valid !== 1'b0 || first_err_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_async got=%0d/%0d/%h/%h/%b/%b want=all0", check_count, error_count,
                     vec_cov, trans_cov, chk_valid, first_err_valid);
        end
        en = 0;
        tick(2);
        rst = 0;
        tick(SETTLE + 3);
        model_clear();
        checks++;
        if (obs_t.size() !== 0) begin
            failures++;
            $display("FAIL rst_abort_pulses got=%0d want=0", obs_t.size());
        end
    endtask

    task automatic test_clear_check();
        build_random(10);
        run_segments("pre_clear");
        obs_t.delete(); obs_p.delete();
        en = 1; {a, b, c} = 3'b110;
        tick(SETTLE);
        clear = 1;
        tick(1);
        clear = 0; en = 0;
        tick(2);
        model_clear();
        checks++;
        if (obs_t.size() !== 0) begin
            failures++;
            $display("FAIL clear_check_pulses got=%0d want=0", obs_t.size());
        end
        checks++;
        if (check_count !== 16'd0 || error_count !== 16'd0 || vec_cov !== 8'd0 ||
            trans_cov !== 64'd0 || first_err_valid !== 1'b0) begin
            failures++;
            $display("FAIL clear_state got=%0d/%0d/%h/%h/%b want=all0", check_count, error_count,
                     vec_cov, trans_cov, first_err_valid);
        end
    endtask

    task automatic test_en_abort();
        bit [7:0] ev;
        build_random(10);
        run_segments("pre_en");
        for (int i = 0; i < 8; i++) ev[i] = m_vseen[i];
        obs_t.delete(); obs_p.delete();
        en = 1; {a, b, c} = 3'(m_last ^ 5);
        tick(2);
        en = 0;
        tick(SETTLE + 3);
        checks++;
        if (obs_t.size() !== 0) begin
            failures++;
            $display("FAIL en_abort_pulses got=%0d want=0", obs_t.size());
        end
        checks++;
        if (check_count !== 16'(m_checks) || error_count !== 16'(m_errs) || vec_cov !== ev) begin
            failures++;
            $display("FAIL en_abort_hold got=%0d/%0d/%h want=%0d/%0d/%h",
                     check_count, error_count, vec_cov, m_checks, m_errs, ev);
        end
    endtask

    task automatic test_saturate();
        bit [63:0] tv;
        tv = '0;
        tv[3*8+7] = 1'b1;
        tv[7*8+3] = 1'b1;
        do_clear();
        stuck = 1;
        seg_v.delete(); seg_h.delete();
        for (int i = 0; i < 10; i++) add_seg((i % 2) ? 7 : 3, 6);
        run_segments("saturate");
        stuck = 0;
        checks++;
        if (s_check_count !== 3'd7 || s_error_count !== 3'd7) begin
            failures++;
            $display("FAIL saturate got=%0d/%0d want=7/7", s_check_count, s_error_count);
        end
        checks++;
        if (s_first_err_valid !== 1'b1 || s_first_err_vec !== 3'b011 || s_first_err_got !== 2'b00 ||
            s_vec_cov !== 8'b1000_1000 || s_trans_cov !== tv || s_all_covered !== 1'b0 ||
            s_chk_valid !== 1'b0 || s_chk_pass !== 1'b0) begin
            failures++;
            $display("FAIL saturate_side got=%b/%b/%b/%h/%h/%b/%b/%b", s_first_err_valid,
                     s_first_err_vec, s_first_err_got, s_vec_cov, s_trans_cov, s_all_covered,
                     s_chk_valid, s_chk_pass);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_stuck();
        test_all_trans();
        test_glitch();
        test_random();
        test_rst_abort();
        test_clear_check();
        test_en_abort();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
